aes_sbox_arbiter: RTL and testbench
===================================

# aes_sbox_arbiter

Shares one 4-lane (32-bit) AES S-box lookup between two requesters: the state path, which needs all 16 bytes of a 128-bit state substituted, and the key-expansion path, which needs one 32-bit SubWord.
- A state job runs as four 32-bit beats through the shared lookup.
- A key word takes one beat and may preempt a state job between beats, with bounded starvation.
- The block sits between the round controller/key scheduler and a combinational 4-byte S-box instance, replacing a full 16-lane substitution.

## Interface
- KEY_BURST, 1, maximum consecutive key grants while a state job is pending (legal 1..3)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_req_valid  in  1  state job offered
- st_req_ready  out  1  state job accepted when high with st_req_valid
- st_req_data  in  [0:127]  state; byte k = bits [8k:8k+7]
- st_rsp_valid  out  1  substituted state available
- st_rsp_ready  in  1  consumer takes st_rsp_data
- st_rsp_data  out  [0:127]  substituted state, same byte order
- kw_req_valid  in  1  key word offered
- kw_req_ready  out  1  key word accepted (and granted) this cycle
- kw_req_data  in  [0:31]  word to substitute
- kw_rsp_valid  out  1  substituted word available
- kw_rsp_ready  in  1  consumer takes kw_rsp_data
- kw_rsp_data  out  [0:31]  substituted word
- sbox_in  out  [0:31]  four bytes to the shared S-box
- sbox_out  in  [0:31]  S-box result, combinational, same cycle
- busy  out  1  state job in flight or kw_rsp_valid high

## Operation
- **State FSM**
  - IDLE: st_req_ready=1. On st_req_valid, capture st_req_data into the input buffer, clear the beat counter b=0, and go to RUN.
  - RUN: on each state grant, sbox_in = buffer bytes 4b..4b+3; sbox_out is written to output-register bytes 4b..4b+3; b increments. The grant with b=3 moves the FSM to DONE.
  - DONE: st_rsp_valid=1 and st_rsp_data stable until st_rsp_ready=1, then IDLE. A new job is accepted no earlier than the cycle after the response handshake.
- **Key path**
  - Single-entry response slot.
  - kw_req_ready = key_grant = kw_req_valid && (!kw_rsp_valid || kw_rsp_ready) && !(FSM==RUN && kcnt==KEY_BURST).
  - On a key grant: sbox_in = kw_req_data; sbox_out is registered into kw_rsp_data and kw_rsp_valid is set next cycle.
  - kw_rsp_valid clears on kw_rsp_ready unless a new grant occurs in the same cycle (the slot refills).
- **Arbitration (combinational, per cycle)**
  - Key wins whenever key_grant is true.
  - Otherwise, if FSM==RUN, the state path is granted.
  - Otherwise sbox_in = 0.
  - At most one grant per cycle.
- **Starvation counter kcnt** (2 bits):
  - Increments on a key grant while FSM==RUN.
  - Clears on a state grant.
  - Clears when FSM != RUN.
- kw_req_ready depends on kw_req_valid. The requester must not make kw_req_valid depend on kw_req_ready.
- Once asserted, requests are held with stable data until accepted, and responses are held with stable data until taken.

## Timing
- **Reset values**: FSM=IDLE, b=0, kcnt=0. Outputs: st_req_ready=1, st_rsp_valid=0, kw_req_ready=0, kw_rsp_valid=0, st_rsp_data=0, kw_rsp_data=0, sbox_in=0, busy=0.
- **Reset mid-job**: the job is aborted, no response is produced, and buffers are cleared.
- **State latency**:
  - Accept at cycle T; beats at T+1..T+4 when uncontested; st_rsp_valid at T+5.
  - Worst case with continuous key traffic: 4 + 4*KEY_BURST RUN cycles, i.e. st_rsp_valid at T+9 for KEY_BURST=1.
- **Key latency**: accept at T, kw_rsp_valid at T+1. Throughput is 1 word/cycle when kw_rsp_ready is held high and no starvation limit applies.
- **Simultaneous events**:
  - A key request arriving in the same cycle as a state accept (FSM IDLE) is granted immediately; the state job's first beat is next cycle.
  - Key grant and state-response handshake in the same cycle are independent.
- **Backpressure**: if kw_rsp_ready=0 with kw_rsp_valid=1, key grants stop and the state job proceeds uncontested.

## Test plan
- **Lone state job**: bytes 00,01,…,0f; key idle.
  - Required: st_rsp_data = 637c777bf26b6fc53001672bfed7ab76.
  - st_rsp_valid exactly 5 cycles after accept.
  - sbox_in sequence 00010203, 04050607, 08090a0b, 0c0d0e0f.
- **Lone key word**: 00531 0ff (bytes 00,53,10,ff).
  - Required: kw_rsp_data = 63edca16 one cycle after accept.
  - Second word 01010101 accepted back-to-back with kw_rsp_ready=1 returns 7c7c7c7c on the next cycle.
- **Contention, KEY_BURST=1**: start the state job above while kw_req_valid is held high, streaming words.
  - Required: grants alternate key/state.
  - State result is unchanged and arrives at T+9.
  - No key grant in two consecutive RUN cycles.
- **Key backpressure**: kw_rsp_ready=0 after one key response.
  - Required: kw_req_ready=0.
  - State job completes at T+5.
  - kw_rsp_data is held stable throughout.
- **State response backpressure**: hold st_rsp_ready=0 for 6 cycles with a second state request pending.
  - Required: st_rsp_data stable and st_req_ready=0 throughout.
  - The second job is accepted the cycle after the handshake.
- **Reset mid-job**: assert rst_n=0 after beat 2.
  - Required: all outputs at reset values.
  - No st_rsp_valid afterwards.
  - A fresh job after release completes normally.

Source files
------------

// File: rtl/aes_sbox_arbiter.sv
// Shares one 4-lane (32-bit) AES S-box between the state path (128-bit jobs,
// four beats each) and the key-expansion path (one 32-bit SubWord per grant).
// Key words win arbitration, but at most KEY_BURST of them (legal 1..3) are
// granted back-to-back while a state job is running.
//
// Handshake rule for every req/rsp pair: a transfer happens in a cycle where
// valid and ready are both high at the rising edge. A source holds valid and
// its data stable until that transfer. kw_req_ready is combinational on
// kw_req_valid, so the key requester must not make valid depend on ready.
//
// Byte order: byte 0 of each bus occupies its most significant eight bits,
// so beat b of a state job carries bytes 4b..4b+3 from the top of the word.
module aes_sbox_arbiter #(
  parameter int KEY_BURST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_req_data,
  output logic         kw_rsp_valid,
  input  logic         kw_rsp_ready,
  output logic [31:0]  kw_rsp_data,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } st_state_t;

  localparam logic [1:0] KB = KEY_BURST[1:0];

  st_state_t    r_state;
  logic [1:0]   r_b;
  logic [1:0]   r_kcnt;
  logic [127:0] r_buf;
  logic [127:0] r_out;
  logic [31:0]  r_kw_data;
  logic         r_kw_valid;

  logic         w_key_limit;
  logic         w_key_grant;
  logic         w_st_grant;
  logic [31:0]  w_beat_word;

  // Key grant needs a free (or draining) response slot and no starvation cap.
  assign w_key_limit = (r_state == ST_RUN) && (r_kcnt == KB);
  assign w_key_grant = kw_req_valid && (!r_kw_valid || kw_rsp_ready) && !w_key_limit;
  assign w_st_grant  = (r_state == ST_RUN) && !w_key_grant;

  // Select the current beat's four bytes from the captured state.
  always_comb begin
    w_beat_word = r_buf[127:96];
    case (r_b)
      2'd0:    w_beat_word = r_buf[127:96];
      2'd1:    w_beat_word = r_buf[95:64];
      2'd2:    w_beat_word = r_buf[63:32];
      default: w_beat_word = r_buf[31:0];
    endcase
  end

  // Route the granted requester onto the shared S-box input; idle drives zero.
  always_comb begin
    sbox_in = '0;
    if (w_key_grant) begin
      sbox_in = kw_req_data;
    end else if (w_st_grant) begin
      sbox_in = w_beat_word;
    end
  end

  // State-job FSM: capture, four substitution beats, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_b     <= '0;
      r_kcnt  <= '0;
      r_buf   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (st_req_valid) begin
            r_buf   <= st_req_data;
            r_b     <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_st_grant) begin
            case (r_b)
              2'd0:    r_out[127:96] <= sbox_out;
              2'd1:    r_out[95:64]  <= sbox_out;
              2'd2:    r_out[63:32]  <= sbox_out;
              default: r_out[31:0]   <= sbox_out;
            endcase
            r_b <= r_b + 2'd1;
            if (r_b == 2'd3) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (st_rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Consecutive key grants are only counted against a running state job.
      if ((r_state != ST_RUN) || w_st_grant) begin
        r_kcnt <= '0;
      end else if (w_key_grant) begin
        r_kcnt <= r_kcnt + 2'd1;
      end
    end
  end

  // Single-entry key response slot; a grant in the draining cycle refills it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kw_valid <= 1'b0;
      r_kw_data  <= '0;
    end else if (w_key_grant) begin
      r_kw_valid <= 1'b1;
      r_kw_data  <= sbox_out;
    end else if (kw_rsp_ready) begin
      r_kw_valid <= 1'b0;
    end
  end

  assign st_req_ready = (r_state == ST_IDLE);
  assign st_rsp_valid = (r_state == ST_DONE);
  assign st_rsp_data  = r_out;
  assign kw_req_ready = w_key_grant;
  assign kw_rsp_valid = r_kw_valid;
  assign kw_rsp_data  = r_kw_data;
  assign busy         = (r_state != ST_IDLE) || r_kw_valid;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Bench for aes_sbox_arbiter: models the external S-box, drives directed
// scenarios and a randomized phase, and scores responses against a byte-wise
// substitution model through expected-value queues.
module tb_aes_sbox_arbiter;

  localparam int KEY_BURST = 1;
  localparam int MAX_LAT   = 1 + 4 + 4 * KEY_BURST;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_req_valid, st_req_ready;
  logic [127:0] st_req_data;
  logic         st_rsp_valid, st_rsp_ready;
  logic [127:0] st_rsp_data;
  logic         kw_req_valid, kw_req_ready;
  logic [31:0]  kw_req_data;
  logic         kw_rsp_valid, kw_rsp_ready;
  logic [31:0]  kw_rsp_data;
  logic [31:0]  sbox_in, sbox_out;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [127:0] st_exp_q[$];
  logic [31:0]  kw_exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[31 - 8 * i -: 8] = sbox_byte(w[31 - 8 * i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = sbox_byte(s[127 - 8 * i -: 8]);
    return r;
  endfunction

  // The shared combinational S-box that the block drives.
  assign sbox_out = sub_word(sbox_in);

  aes_sbox_arbiter #(.KEY_BURST(KEY_BURST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_req_valid (st_req_valid),
    .st_req_ready (st_req_ready),
    .st_req_data  (st_req_data),
    .st_rsp_valid (st_rsp_valid),
    .st_rsp_ready (st_rsp_ready),
    .st_rsp_data  (st_rsp_data),
    .kw_req_valid (kw_req_valid),
    .kw_req_ready (kw_req_ready),
    .kw_req_data  (kw_req_data),
    .kw_rsp_valid (kw_rsp_valid),
    .kw_rsp_ready (kw_rsp_ready),
    .kw_rsp_data  (kw_rsp_data),
    .sbox_in      (sbox_in),
    .sbox_out     (sbox_out),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"},
          128'({st_req_ready, st_rsp_valid, kw_req_ready, kw_rsp_valid, busy}), 128'h10);
    check({tag, "_st_rsp_data"}, st_rsp_data, '0);
    check({tag, "_kw_rsp_data"}, 128'(kw_rsp_data), '0);
    check({tag, "_sbox_in"}, 128'(sbox_in), '0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    st_req_valid = 1'b0;
    st_req_data  = '0;
    st_rsp_ready = 1'b1;
    kw_req_valid = 1'b0;
    kw_req_data  = '0;
    kw_rsp_ready = 1'b1;
  endtask

  task automatic wait_st_rsp(input string name, output logic [127:0] d, output int at_cyc);
    bit found = 1'b0;
    d      = '0;
    at_cyc = -1;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (st_rsp_valid) begin
        found  = 1'b1;
        d      = st_rsp_data;
        at_cyc = cyc;
      end
    end
    if (!found) check({name, "_timeout"}, 128'd0, 128'd1);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit           kw_acc_prev, kw_hold_prev, st_hold_prev, st_waiting;
  logic [31:0]  kw_hold_data;
  logic [127:0] st_hold_data;
  int           st_acc_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      st_exp_q.delete();
      kw_exp_q.delete();
      kw_acc_prev  = 1'b0;
      kw_hold_prev = 1'b0;
      st_hold_prev = 1'b0;
      st_waiting   = 1'b0;
    end else begin
      if (kw_hold_prev) check("kw_rsp_hold", {kw_rsp_valid, kw_rsp_data}, {1'b1, kw_hold_data});
      if (st_hold_prev) check("st_rsp_hold", {st_rsp_valid, st_rsp_data}, {1'b1, st_hold_data});
      if (kw_acc_prev) check("kw_latency", 128'(kw_rsp_valid), 128'd1);

      if (kw_rsp_valid && kw_rsp_ready) begin
        if (kw_exp_q.size() == 0) check("kw_rsp_unexpected", 128'd1, 128'd0);
        else check("kw_rsp_data", 128'(kw_rsp_data), 128'(kw_exp_q.pop_front()));
      end
      if (st_rsp_valid && st_rsp_ready) begin
        if (st_exp_q.size() == 0) check("st_rsp_unexpected", 128'd1, 128'd0);
        else check("st_rsp_data", st_rsp_data, st_exp_q.pop_front());
      end

      if (st_waiting && st_rsp_valid) begin
        check_range("st_latency_bound", cyc - st_acc_cyc, 5, MAX_LAT);
        st_waiting = 1'b0;
      end

      if (kw_req_valid && kw_req_ready) begin
        check("kw_sbox_in", 128'(sbox_in), 128'(kw_req_data));
        kw_exp_q.push_back(sub_word(kw_req_data));
      end
      if (st_req_valid && st_req_ready) begin
        st_exp_q.push_back(sub_state(st_req_data));
        st_acc_cyc = cyc;
        st_waiting = 1'b1;
      end

      kw_acc_prev  = kw_req_valid && kw_req_ready;
      kw_hold_prev = kw_rsp_valid && !kw_rsp_ready;
      kw_hold_data = kw_rsp_data;
      st_hold_prev = st_rsp_valid && !st_rsp_ready;
      st_hold_data = st_rsp_data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] d, d2, data_a, data_b, beat_seq;
    logic [31:0]  w1, w2;
    logic [9:0]   grants, exp_grants, rsp_at;
    logic [5:0]   rsp_vec;
    logic [1:0]   dbg_idle, dbg_run;
    int           t_acc, t_rsp, st_beats;
    bit           ok_a, ok_b;

    idle_inputs();
    rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Lone state job, key idle
    step();
    st_req_valid = 1'b1;
    st_req_data  = 128'h000102030405060708090a0b0c0d0e0f;
    @(negedge clk);
    check("t1_accept", 128'(st_req_ready), 128'd1);
    t_acc    = cyc;
    dbg_idle = dbg_state;
    step();
    st_req_valid = 1'b0;
    beat_seq = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) dbg_run = dbg_state;
      beat_seq = {beat_seq[95:0], sbox_in};
    end
    check("t1_sbox_in_seq", beat_seq, 128'h000102030405060708090a0b0c0d0e0f);
    check("t1_dbg_state_moves", 128'(dbg_run != dbg_idle), 128'd1);
    wait_st_rsp("t1", d, t_rsp);
    check("t1_rsp_data", d, 128'h637c777bf26b6fc53001672bfed7ab76);
    check("t1_latency", 128'(t_rsp - t_acc), 128'd5);
    step();

    // Lone key word, then a back-to-back second word
    step();
    kw_req_valid = 1'b1;
    kw_req_data  = 32'h005310ff;
    @(negedge clk);
    check("t2_kw_accept", 128'(kw_req_ready), 128'd1);
    step();
    kw_req_data = 32'h01010101;
    @(negedge clk);
    check("t2_kw_rsp1", 128'({kw_rsp_valid, kw_rsp_data}), 128'({1'b1, 32'h63edca16}));
    check("t2_kw_accept2", 128'(kw_req_ready), 128'd1);
    step();
    kw_req_valid = 1'b0;
    @(negedge clk);
    check("t2_kw_rsp2", 128'({kw_rsp_valid, kw_rsp_data}), 128'({1'b1, 32'h7c7c7c7c}));
    step();
    step();

    // Contention: state job against a continuous key stream
    st_req_valid = 1'b1;
    st_req_data  = 128'h000102030405060708090a0b0c0d0e0f;
    kw_req_valid = 1'b1;
    kw_req_data  = $urandom();
    grants = '0; exp_grants = '0; rsp_at = '0; beat_seq = '0; st_beats = 0; d = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) check("t3_accept", 128'(st_req_ready), 128'd1);
      grants[c]     = kw_req_ready;
      exp_grants[c] = (c == 0) || (c == 9) || (c % 2 == 1);
      rsp_at[c]     = st_rsp_valid;
      if (st_rsp_valid) d = st_rsp_data;
      if (c >= 1 && c <= 8 && !kw_req_ready) begin
        beat_seq = {beat_seq[95:0], sbox_in};
        st_beats++;
      end
      step();
      if (c == 0) st_req_valid = 1'b0;
      if (grants[c]) kw_req_data = $urandom();
    end
    kw_req_valid = 1'b0;
    check("t3_grant_pattern", 128'(grants), 128'(exp_grants));
    check("t3_rsp_at_t9", 128'(rsp_at), 128'(10'b10_0000_0000));
    check("t3_state_beats", 128'(st_beats), 128'd4);
    check("t3_sbox_in_seq", beat_seq, 128'h000102030405060708090a0b0c0d0e0f);
    check("t3_rsp_data", d, 128'h637c777bf26b6fc53001672bfed7ab76);
    step();
    step();

    // Key response backpressure
    kw_rsp_ready = 1'b0;
    w1 = $urandom();
    w2 = $urandom();
    data_a = rand128();
    kw_req_valid = 1'b1;
    kw_req_data  = w1;
    @(negedge clk);
    check("t4_kw_accept", 128'(kw_req_ready), 128'd1);
    step();
    kw_req_data  = w2;
    st_req_valid = 1'b1;
    st_req_data  = data_a;
    ok_a = 1'b1; ok_b = 1'b1; rsp_vec = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) check("t4_st_accept", 128'(st_req_ready), 128'd1);
      if (kw_req_ready) ok_a = 1'b0;
      if (kw_rsp_data !== sub_word(w1) || !kw_rsp_valid) ok_b = 1'b0;
      rsp_vec[c] = st_rsp_valid;
      if (st_rsp_valid) d = st_rsp_data;
      step();
      if (c == 0) st_req_valid = 1'b0;
    end
    check("t4_kw_blocked", 128'(ok_a), 128'd1);
    check("t4_kw_held", 128'(ok_b), 128'd1);
    check("t4_st_rsp_at_t5", 128'(rsp_vec), 128'(6'b100000));
    check("t4_st_rsp_data", d, sub_state(data_a));
    kw_rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_kw_resume", 128'(kw_req_ready), 128'd1);
    step();
    kw_req_valid = 1'b0;
    step();

    // State response backpressure with a second job pending
    st_rsp_ready = 1'b0;
    data_a = rand128();
    data_b = rand128();
    st_req_valid = 1'b1;
    st_req_data  = data_a;
    @(negedge clk);
    check("t5_accept_a", 128'(st_req_ready), 128'd1);
    step();
    st_req_data = data_b;
    wait_st_rsp("t5_a", d, t_rsp);
    check("t5_rsp_a", d, sub_state(data_a));
    ok_a = 1'b1;
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      if (!st_rsp_valid || st_rsp_data !== d || st_req_ready) ok_a = 1'b0;
    end
    check("t5_hold_stable", 128'(ok_a), 128'd1);
    step();
    st_rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_no_accept_in_handshake", 128'({st_rsp_valid, st_req_ready}), 128'(2'b10));
    step();
    @(negedge clk);
    check("t5_accept_b_next_cycle", 128'(st_req_ready), 128'd1);
    step();
    st_req_valid = 1'b0;
    wait_st_rsp("t5_b", d2, t_rsp);
    check("t5_rsp_b", d2, sub_state(data_b));
    step();

    // Reset in the middle of a job
    data_a = rand128();
    st_req_valid = 1'b1;
    st_req_data  = data_a;
    @(negedge clk);
    check("t6_accept", 128'(st_req_ready), 128'd1);
    step();
    st_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_reset");
    step();
    step();
    rst_n = 1'b1;
    ok_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (st_rsp_valid) ok_a = 1'b0;
    end
    check("t6_no_rsp_after_reset", 128'(ok_a), 128'd1);
    step();
    data_b = rand128();
    st_req_valid = 1'b1;
    st_req_data  = data_b;
    @(negedge clk);
    check("t6_fresh_accept", 128'(st_req_ready), 128'd1);
    t_acc = cyc;
    step();
    st_req_valid = 1'b0;
    wait_st_rsp("t6_fresh", d, t_rsp);
    check("t6_fresh_data", d, sub_state(data_b));
    check("t6_fresh_latency", 128'(t_rsp - t_acc), 128'd5);
    step();

    // Randomized traffic with random backpressure on both responses
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      ok_a = st_req_valid && st_req_ready;
      ok_b = kw_req_valid && kw_req_ready;
      step();
      if (!st_req_valid || ok_a) begin
        st_req_valid = ($urandom_range(0, 3) == 0);
        st_req_data  = rand128();
      end
      if (!kw_req_valid || ok_b) begin
        kw_req_valid = ($urandom_range(0, 1) == 1);
        kw_req_data  = $urandom();
      end
      st_rsp_ready = ($urandom_range(0, 1) == 1);
      kw_rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain: hold any pending request until it is taken, then go quiet
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      ok_a = st_req_valid && st_req_ready;
      ok_b = kw_req_valid && kw_req_ready;
      step();
      st_rsp_ready = 1'b1;
      kw_rsp_ready = 1'b1;
      if (ok_a) st_req_valid = 1'b0;
      if (ok_b) kw_req_valid = 1'b0;
    end
    @(negedge clk);
    check("requests_drained", 128'({st_req_valid, kw_req_valid}), 128'd0);
    check("scoreboard_drained", 128'(st_exp_q.size() + kw_exp_q.size()), 128'd0);
    check("idle_at_end", 128'(busy), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck handshake still produces a report.
  initial begin
    #200000;
    check("watchdog_timeout", 128'd0, 128'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
